// File: rtl/m_pcgen.sv
// m_pcgen: program counter generator with boot/run/halt control, trap entry,
// branch/call/return redirects and a circular return-address stack.
module m_pcgen #(
   parameter int               XLEN      = 32,
   parameter int               STEP      = 4,
   parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(32'h0),
   parameter logic [XLEN-1:0]  TRAP_VEC  = XLEN'(32'h100),
   parameter int               RAS_DEPTH = 4
) (
   input  logic            w_clk,
   input  logic            w_rst,
   input  logic            w_stall,
   input  logic            w_br_taken,
   input  logic [XLEN-1:0] w_br_tgt,
   input  logic            w_call,
   input  logic [XLEN-1:0] w_jmp_tgt,
   input  logic            w_ret,
   input  logic [XLEN-1:0] w_ret_tgt,
   input  logic            w_trap,
   input  logic            w_halt,
   input  logic            w_resume,
   output logic [XLEN-1:0] w_pc,
   output logic            w_pc_valid,
   output logic [XLEN-1:0] w_epc,
   output logic            w_ras_ovf,
   output logic            w_misalign
);

   localparam int              PTR_W    = $clog2(RAS_DEPTH);
   localparam logic [XLEN-1:0] STEP_INC = XLEN'(STEP);
   localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);
   localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(RAS_DEPTH);
   localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

   state_t           state;
   state_t           state_nxt;

   logic [XLEN-1:0]  ras [RAS_DEPTH];
   logic [PTR_W-1:0] ras_ptr;
   logic [PTR_W-1:0] ras_ptr_nxt;
   logic [PTR_W:0]   ras_cnt;
   logic [PTR_W:0]   ras_cnt_nxt;
   logic             ras_we;
   logic [PTR_W-1:0] ras_waddr;
   logic [XLEN-1:0]  ras_wdata;

   logic [XLEN-1:0]  pc_seq;
   logic [XLEN-1:0]  pc_nxt;
   logic [XLEN-1:0]  epc_nxt;
   logic [XLEN-1:0]  tgt;
   logic             redirect;
   logic             run_go;
   logic             ovf_nxt;
   logic             mis_nxt;

   // State register: reset always lands in S_BOOT
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state <= S_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: trap forces S_RUN from anywhere; a stalled cycle cannot halt
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_BOOT:  state_nxt = S_RUN;
         S_RUN:   if (!w_stall && w_halt) state_nxt = S_HALT;
         S_HALT:  if (w_resume) state_nxt = S_RUN;
         default: state_nxt = S_BOOT;
      endcase
      if (w_trap) begin
         state_nxt = S_RUN;
      end
   end

   // Output logic: only the run state presents a fetchable PC
   always_comb begin
      w_pc_valid = (state == S_RUN);
   end

   // Next-PC and RAS update selection; halt holds the PC, so it also masks redirects
   always_comb begin
      pc_seq      = w_pc + STEP_INC;
      run_go      = (state == S_RUN) && !w_stall && !w_halt;
      pc_nxt      = w_pc;
      epc_nxt     = w_epc;
      tgt         = '0;
      redirect    = 1'b0;
      ovf_nxt     = 1'b0;
      mis_nxt     = 1'b0;
      ras_we      = 1'b0;
      ras_waddr   = '0;
      ras_wdata   = '0;
      ras_ptr_nxt = ras_ptr;
      ras_cnt_nxt = ras_cnt;
      if (w_trap) begin
         pc_nxt  = TRAP_VEC;
         epc_nxt = w_pc;
      end else if (run_go) begin
         if (w_br_taken) begin
            tgt      = w_br_tgt;
            redirect = 1'b1;
         end else if (w_call) begin
            tgt       = w_jmp_tgt;
            redirect  = 1'b1;
            ras_we    = 1'b1;
            ras_wdata = pc_seq;
            if (w_ret && (ras_cnt != '0)) begin
               ras_waddr = ras_ptr;
            end else begin
               ras_waddr   = ras_ptr + PTR_ONE;
               ras_ptr_nxt = ras_ptr + PTR_ONE;
               if (ras_cnt == CNT_FULL) begin
                  ovf_nxt = 1'b1;
               end else begin
                  ras_cnt_nxt = ras_cnt + CNT_ONE;
               end
            end
         end else if (w_ret) begin
            redirect = 1'b1;
            if (ras_cnt != '0) begin
               tgt         = ras[ras_ptr];
               ras_ptr_nxt = ras_ptr - PTR_ONE;
               ras_cnt_nxt = ras_cnt - CNT_ONE;
            end else begin
               tgt = w_ret_tgt;
            end
         end else begin
            pc_nxt = pc_seq;
         end
         if (redirect) begin
            pc_nxt  = tgt & ~LOW_MASK;
            mis_nxt = |(tgt & LOW_MASK);
         end
      end
   end

   // PC, EPC, RAS bookkeeping and the one-cycle status pulses
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         w_pc       <= RESET_VEC;
         w_epc      <= '0;
         ras_ptr    <= '0;
         ras_cnt    <= '0;
         w_ras_ovf  <= 1'b0;
         w_misalign <= 1'b0;
      end else begin
         w_pc       <= pc_nxt;
         w_epc      <= epc_nxt;
         ras_ptr    <= ras_ptr_nxt;
         ras_cnt    <= ras_cnt_nxt;
         w_ras_ovf  <= ovf_nxt;
         w_misalign <= mis_nxt;
      end
   end

   // RAS storage; entries beyond the count are don't-care so they carry no reset
   always_ff @(posedge w_clk) begin
      if (ras_we && !w_rst) begin
         ras[ras_waddr] <= ras_wdata;
      end
   end

endmodule

// File: doc/m_pcgen.md
M_PCGEN -- requirements
Module: m_pcgen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and target width in bits.
REQ-002 SHALL have parameter STEP, default 4, sequential increment; power of two, at least 1.
REQ-003 SHALL have parameter RESET_VEC, default 32'h0, PC value loaded on reset.
REQ-004 SHALL have parameter TRAP_VEC, default 32'h100, PC value loaded on trap.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
REQ-006 SHALL have port w_clk  in  1  the only clock; all state updates on its rising edge.
REQ-007 SHALL have port w_rst  in  1  synchronous active-high reset.
REQ-008 SHALL have port w_stall  in  1  hold PC; ignores all redirects except trap.
REQ-009 SHALL have port w_br_taken  in  1  taken branch, target w_br_tgt.
REQ-010 SHALL have port w_br_tgt  in  XLEN  branch target.
REQ-011 SHALL have port w_call  in  1  call: jump to w_jmp_tgt and push w_pc+STEP.
REQ-012 SHALL have port w_jmp_tgt  in  XLEN  call target.
REQ-013 SHALL have port w_ret  in  1  return: pop RAS; on empty RAS use w_ret_tgt.
REQ-014 SHALL have port w_ret_tgt  in  XLEN  fallback return target.
REQ-015 SHALL have port w_trap  in  1  trap request.
REQ-016 SHALL have port w_halt  in  1  enter halt.
REQ-017 SHALL have port w_resume  in  1  leave halt.
REQ-018 SHALL have port w_pc  out  XLEN  registered current fetch PC.
REQ-019 SHALL have port w_pc_valid  out  1  w_pc is a valid fetch address.
REQ-020 SHALL have port w_epc  out  XLEN  PC captured at the last trap.
REQ-021 SHALL have port w_ras_ovf  out  1  one-cycle pulse when a push overwrites the oldest entry.
REQ-022 SHALL have port w_misalign  out  1  one-cycle pulse when a redirect target was misaligned.

Function
REQ-023 SHALL implement FSM states S_BOOT, S_RUN, S_HALT; w_pc_valid=1 only in S_RUN.
REQ-024 SHALL go S_BOOT->S_RUN unconditionally on the next edge, keeping w_pc=RESET_VEC, so the first valid fetch is RESET_VEC.
REQ-025 SHALL, in S_RUN without stall, select next PC by priority: trap > branch > call > ret > w_pc+STEP.
REQ-026 SHALL make every selection visible on w_pc at the edge ending the request cycle (latency 1); inputs are sampled only at that edge.
REQ-027 SHALL, on trap in any state (including stalled or S_HALT), load w_pc=TRAP_VEC, set w_epc=current w_pc, and enter S_RUN.
REQ-028 SHALL, under w_stall in S_RUN without trap, hold w_pc and RAS and ignore branch/call/ret/halt.
REQ-029 SHALL, on w_halt in S_RUN (not stalled, no trap), hold w_pc and enter S_HALT; resume takes priority over halt in S_HALT.
REQ-030 SHALL hold w_pc in S_HALT; on w_resume, enter S_RUN with w_pc unchanged.
REQ-031 SHALL compute all PC arithmetic modulo 2^XLEN; w_pc+STEP wraps from all-ones to low addresses without any flag.
REQ-032 SHALL clear the low log2(STEP) bits of a selected branch/call/ret target that has any of them set, and pulse w_misalign for one cycle.
REQ-033 SHALL implement the RAS as a circular buffer with a top pointer and a count saturating at RAS_DEPTH.
REQ-034 SHALL, on a call push with count=RAS_DEPTH, overwrite the oldest entry, keep count, and pulse w_ras_ovf.
REQ-035 SHALL, on ret with count>0, go to the top entry and decrement count; with count=0, go to w_ret_tgt with RAS unchanged.
REQ-036 SHALL, on call and ret in the same cycle, have call win: replace the top entry with w_pc+STEP (push if empty), count unchanged except 0->1.
REQ-037 SHALL leave the RAS unchanged when a higher-priority trap or branch wins over call/ret.

Reset
REQ-038 SHALL, on w_rst=1 at an edge, regardless of state or other inputs, set w_pc=RESET_VEC, w_pc_valid=0, w_epc=0, RAS count=0, pointer=0, w_ras_ovf=0, w_misalign=0, and state S_BOOT.
REQ-039 SHALL, if reset occurs mid-halt or mid-stall, discard all pending activity; the next valid fetch is RESET_VEC.

Verification
REQ-040 SHALL cover reset then free run: defaults -> w_pc 0 (valid from the second cycle), 0, 4, 8, 12 on successive cycles.
REQ-041 SHALL cover branch vs call: w_br_taken=1 to 0x40 together with w_call=1 to 0x80 -> w_pc=0x40, RAS count stays 0.
REQ-042 SHALL cover RAS overflow: 5 calls at PCs 0x10, 0x20, 0x30, 0x40, 0x50 (depth 4) -> w_ras_ovf pulses on the 5th call; 4 rets return 0x54, 0x44, 0x34, 0x24; a 5th ret goes to w_ret_tgt.
REQ-043 SHALL cover trap during stall+halt: in S_HALT at w_pc=0x200, w_trap=1 -> w_pc=0x100, w_epc=0x200, w_pc_valid=1.
REQ-044 SHALL cover misalignment: branch to 0x43 -> w_pc=0x40, w_misalign high for exactly one cycle.
REQ-045 SHALL cover wrap-around: XLEN=8, w_pc=0xFC, no redirect -> next w_pc=0x00.
